// File: rtl/or1200_tb_pkg.sv
// Shared types and constants for the OR1200 testbench Wishbone SRAM model.
package or1200_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BURST,
    ST_ERR
  } wb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // l.nop, the power-up contents of every word
  localparam logic [31:0] NOP = 32'h1500_0000;

endpackage

// File: rtl/or1200_tb_wb_sram_if.sv
// Wishbone B3 bus between an OR1200 master port and the SRAM model.
interface or1200_tb_wb_sram_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/or1200_tb_burst_addr.sv
// Next word address of an incrementing burst: linear or wrap-4/8/16.
module or1200_tb_burst_addr
  import or1200_tb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [1:0]            bte_i,
  output logic [ADDR_WIDTH-1:0] adr_o
);
  logic [ADDR_WIDTH-1:0] inc;

  assign inc = adr_i + ADDR_WIDTH'(1);

  // wrap bursts only advance the low bits, the block base is held
  always_comb begin
    adr_o = inc;
    case (bte_i)
      BTE_WRAP4:  adr_o = {adr_i[ADDR_WIDTH-1:2], inc[1:0]};
      BTE_WRAP8:  adr_o = {adr_i[ADDR_WIDTH-1:3], inc[2:0]};
      BTE_WRAP16: adr_o = {adr_i[ADDR_WIDTH-1:4], inc[3:0]};
      default:    adr_o = inc;
    endcase
  end
endmodule

// File: rtl/or1200_tb_wb_sram.sv
// Wait-state-programmable Wishbone B3 SRAM slave with classic/burst cycles,
// byte lanes, out-of-range error and a backdoor load port.
module or1200_tb_wb_sram
  import or1200_tb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] INIT_WORD   = NOP
) (
  input  logic                  clk,
  input  logic                  rst,
  or1200_tb_wb_sram_if.slave    wb,
  input  logic                  bd_we_i,
  input  logic [ADDR_WIDTH-1:0] bd_adr_i,
  input  logic [31:0]           bd_dat_i,
  output logic [31:0]           beat_cnt_o
);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e             state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d, adr_nxt;
  logic [2:0]            cti_q, cti_d;
  logic [1:0]            bte_q, bte_d;
  logic                  oor_q, oor_d;
  logic                  req, in_range, lin_end, ack, err;
  logic                  unused;

  // The array is deliberately outside reset so loaded programs survive rst.
  logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

  assign req      = wb.wb_cyc_i & wb.wb_stb_i;
  assign in_range = (wb.wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign lin_end  = (bte_q == BTE_LINEAR) && (&adr_q);
  assign unused   = ^wb.wb_adr_i[1:0];

  or1200_tb_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_burst_addr (
    .adr_i (adr_q),
    .bte_i (bte_q),
    .adr_o (adr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      adr_q   <= '0;
      cti_q   <= CTI_CLASSIC;
      bte_q   <= BTE_LINEAR;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      adr_q   <= adr_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    adr_d   = adr_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    oor_d   = oor_q;
    ack     = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE: if (req) begin
        adr_d = wb.wb_adr_i[ADDR_WIDTH+1:2];
        cti_d = wb.wb_cti_i;
        bte_d = wb.wb_bte_i;
        oor_d = 1'b0;
        if (!in_range)            state_d = ST_ERR;
        else if (WAIT_STATES == 0) state_d = ST_ACK;
        else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (!wb.wb_cyc_i)        state_d = ST_IDLE;
        else if (wait_q == '0)   state_d = ST_ACK;
        else                     wait_d  = wait_q - 4'd1;
      end
      ST_ACK: begin
        ack = 1'b1;
        if (cti_q == CTI_INCR && wb.wb_cti_i != CTI_EOB && wb.wb_cyc_i) begin
          state_d = ST_BURST;
          adr_d   = adr_nxt;
          oor_d   = lin_end;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!wb.wb_cyc_i) state_d = ST_IDLE;
        else if (wb.wb_stb_i) begin
          // a linear burst that ran past the top word errors instead of wrapping
          if (oor_q) state_d = ST_ERR;
          else begin
            ack = 1'b1;
            if (wb.wb_cti_i == CTI_EOB) state_d = ST_IDLE;
            else begin
              adr_d = adr_nxt;
              oor_d = lin_end;
            end
          end
        end
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // backdoor is written last so it wins a same-word collision
  always_ff @(posedge clk) begin
    if (ack && wb.wb_we_i)
      for (int i = 0; i < 4; i++)
        if (wb.wb_sel_i[i]) mem[adr_q][8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
    if (bd_we_i) mem[bd_adr_i] <= bd_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          beat_cnt_o <= '0;
    else if (ack && beat_cnt_o != '1) beat_cnt_o <= beat_cnt_o + 32'd1;
  end

  assign wb.wb_ack_o = ack;
  assign wb.wb_err_o = err;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = (ack && !wb.wb_we_i) ? mem[adr_q] : '0;

endmodule
